// File: rtl/uart_pkg.sv
// Shared UART definitions: FIFO geometry, trigger levels, RX entry layout.
package uart_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int RX_W      = 10;

  localparam logic [4:0] TRIG_1  = 5'd1;
  localparam logic [4:0] TRIG_4  = 5'd4;
  localparam logic [4:0] TRIG_8  = 5'd8;
  localparam logic [4:0] TRIG_14 = 5'd14;

  localparam logic [1:0] FTL_1  = 2'b00;
  localparam logic [1:0] FTL_4  = 2'b01;
  localparam logic [1:0] FTL_8  = 2'b10;
  localparam logic [1:0] FTL_14 = 2'b11;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic [4:0] trig_level(input logic [1:0] ftl);
    logic [4:0] t;
    t = TRIG_1;
    unique case (1'b1)
      ftl == FTL_1:  t = TRIG_1;
      ftl == FTL_4:  t = TRIG_4;
      ftl == FTL_8:  t = TRIG_8;
      ftl == FTL_14: t = TRIG_14;
      default:       t = TRIG_1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-file FIFO storage: synchronous write, asynchronous read.
// Shared by the RX and TX FIFO controllers.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = RX_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// 16550 receive FIFO controller: occupancy, overrun, trigger level
// and character-timeout flags for line status and interrupt logic.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TO_CHARS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FIFOEN,
  input  logic       RXCLR,
  input  logic [1:0] RXFIFTL,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_pe,
  input  logic       rx_fe,
  input  logic       char_tick,
  input  logic       rd_en,
  input  logic       lsr_rd,
  output logic [7:0] rd_data,
  output logic       rd_pe,
  output logic       rd_fe,
  output logic       DR,
  output logic       OE,
  output logic [4:0] rx_level,
  output logic       rda,
  output logic       cti
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] TO_MAX = 3'(TO_CHARS);

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [4:0]    count;
  logic [2:0]    tcnt;
  logic          fifoen_q;
  logic          oe_q;

  logic       empty, flush, push, pop, ovr;
  logic [4:0] cap;
  rx_entry_t  head;
  rx_entry_t  wr_entry;

  assign empty = (count == 5'd0);
  assign cap   = FIFOEN ? 5'(DEPTH) : 5'd1;
  assign flush = RXCLR | (FIFOEN != fifoen_q);

  // A pop frees a slot, so a full FIFO still takes a same-cycle push.
  assign pop  = rd_en & ~empty & ~flush;
  assign push = rx_valid & ((count < cap) | pop) & ~flush;
  assign ovr  = rx_valid & ~push & ~flush;

  assign wr_entry = '{fe: rx_fe, pe: rx_pe, data: rx_data};

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (RX_W)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      tcnt     <= '0;
      oe_q     <= 1'b0;
      fifoen_q <= FIFOEN;
    end else begin
      fifoen_q <= FIFOEN;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        tcnt   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + 5'(push) - 5'(pop);
        if (push | pop | empty)
          tcnt <= '0;
        else if (char_tick && tcnt < TO_MAX)
          tcnt <= tcnt + 3'd1;
      end
      if (ovr)
        oe_q <= 1'b1;
      else if (lsr_rd)
        oe_q <= 1'b0;
    end
  end

  assign rd_data  = empty ? 8'h00 : head.data;
  assign rd_pe    = ~empty & head.pe;
  assign rd_fe    = ~empty & head.fe;
  assign DR       = ~empty;
  assign OE       = oe_q;
  assign rx_level = count;
  assign rda      = FIFOEN ? (count >= trig_level(RXFIFTL)) : ~empty;
  assign cti      = FIFOEN & ~empty & (tcnt == TO_MAX);

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: directed scenarios then random traffic,
// all checked against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FIFOEN;
  logic       RXCLR;
  logic [1:0] RXFIFTL;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_pe, rx_fe;
  logic       char_tick;
  logic       rd_en;
  logic       lsr_rd;
  logic [7:0] rd_data;
  logic       rd_pe, rd_fe;
  logic       DR, OE;
  logic [4:0] rx_level;
  logic       rda, cti;

  int n_vec  = 0;
  int n_miss = 0;

  logic [9:0] q[$];
  bit         m_oe;
  int         m_idle;
  bit         m_prev;

  uart_rx_fifo_ctrl dut (
    .CLK(CLK), .RST(RST), .FIFOEN(FIFOEN), .RXCLR(RXCLR),
    .RXFIFTL(RXFIFTL), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_pe(rx_pe), .rx_fe(rx_fe), .char_tick(char_tick),
    .rd_en(rd_en), .lsr_rd(lsr_rd), .rd_data(rd_data),
    .rd_pe(rd_pe), .rd_fe(rd_fe), .DR(DR), .OE(OE),
    .rx_level(rx_level), .rda(rda), .cti(cti)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int trig(input logic [1:0] f);
    int t[4] = '{1, 4, 8, 14};
    return t[f];
  endfunction

  // Behavioural view: the FIFO is a queue, the timeout an idle-char count.
  task automatic model_edge();
    int  cap;
    bit  do_pop, do_push;
    if (RST) begin
      q.delete();
      m_oe = 0; m_idle = 0; m_prev = FIFOEN;
      return;
    end
    cap = FIFOEN ? 16 : 1;
    if (RXCLR || FIFOEN != m_prev) begin
      q.delete();
      m_idle = 0;
      if (lsr_rd) m_oe = 0;
    end else begin
      do_pop  = rd_en && q.size() > 0;
      do_push = rx_valid && (q.size() < cap || do_pop);
      if (q.size() == 0 || do_push || do_pop) m_idle = 0;
      else if (char_tick && m_idle < 4) m_idle++;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({rx_fe, rx_pe, rx_data});
      if (rx_valid && !do_push) m_oe = 1;
      else if (lsr_rd) m_oe = 0;
    end
    m_prev = FIFOEN;
  endtask

  task automatic check_all();
    int sz;
    logic [9:0] h;
    sz = q.size();
    h  = sz > 0 ? q[0] : 10'h000;
    check("rd_data", int'(rd_data), int'(h[7:0]));
    check("rd_pe", int'(rd_pe), int'(h[8]));
    check("rd_fe", int'(rd_fe), int'(h[9]));
    check("DR", int'(DR), int'(sz > 0));
    check("OE", int'(OE), int'(m_oe));
    check("rx_level", int'(rx_level), sz);
    check("rda", int'(rda), FIFOEN ? int'(sz >= trig(RXFIFTL)) : int'(sz > 0));
    check("cti", int'(cti), int'(FIFOEN && sz > 0 && m_idle == 4));
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
    RXCLR = 0; rx_valid = 0; rx_pe = 0; rx_fe = 0;
    char_tick = 0; rd_en = 0; lsr_rd = 0;
  endtask

  task automatic push(input logic [7:0] d);
    rx_valid = 1; rx_data = d; cyc();
  endtask

  task automatic pop();
    rd_en = 1; cyc();
  endtask

  initial begin
    RST = 1; FIFOEN = 1; RXCLR = 0; RXFIFTL = 2'b01;
    rx_valid = 0; rx_data = 0; rx_pe = 0; rx_fe = 0;
    char_tick = 0; rd_en = 0; lsr_rd = 0;
    cyc();
    check("rst_level", int'(rx_level), 0);
    check("rst_oe", int'(OE), 0);
    RST = 0;
    cyc();

    push(8'h41); push(8'h42); push(8'h43);
    check("lvl3", int'(rx_level), 3);
    check("rda_lvl3", int'(rda), 0);
    push(8'h44);
    check("rda_lvl4", int'(rda), 1);
    for (int i = 0; i < 4; i++) begin
      check("order", int'(rd_data), 8'h41 + i);
      pop();
    end
    check("dr_empty", int'(DR), 0);

    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'h99);
    check("oe_set", int'(OE), 1);
    check("lvl_full", int'(rx_level), 16);
    lsr_rd = 1; cyc();
    check("oe_clr", int'(OE), 0);
    rx_valid = 1; rx_data = 8'h77; rd_en = 1; cyc();
    check("full_pp_lvl", int'(rx_level), 16);
    check("full_pp_oe", int'(OE), 0);
    for (int i = 0; i < 16; i++) pop();

    FIFOEN = 0; cyc();
    push(8'h10); push(8'h11);
    check("hold_head", int'(rd_data), 8'h10);
    check("hold_oe", int'(OE), 1);
    check("hold_rda", int'(rda), 1);
    for (int i = 0; i < 6; i++) begin
      char_tick = 1; cyc();
      check("hold_cti", int'(cti), 0);
    end
    lsr_rd = 1; rd_en = 1; cyc();

    FIFOEN = 1; cyc();
    push(8'h55);
    for (int i = 0; i < 4; i++) begin
      check("cti_pre", int'(cti), 0);
      char_tick = 1; cyc();
    end
    check("cti_set", int'(cti), 1);
    pop();
    check("cti_clr", int'(cti), 0);
    check("cti_dr", int'(DR), 0);

    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    RXCLR = 1; rx_valid = 1; rx_data = 8'hEE; cyc();
    check("clr_lvl", int'(rx_level), 0);
    check("clr_dr", int'(DR), 0);
    push(8'h30); push(8'h31);
    FIFOEN = 0; cyc();
    check("tog_lvl", int'(rx_level), 0);
    FIFOEN = 1; cyc();

    rx_fe = 1; rx_pe = 0; push(8'h5A);
    check("head_fe", int'(rd_fe), 1);
    check("head_pe", int'(rd_pe), 0);
    for (int i = 0; i < 40; i++) begin
      rx_valid = 1; rx_data = 8'(8'h80 + i); rd_en = 1; cyc();
    end
    pop();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) FIFOEN = ~FIFOEN;
      if ($urandom_range(0, 19) == 0) RXFIFTL = 2'($urandom_range(0, 3));
      RXCLR     = ($urandom_range(0, 59) == 0);
      rx_valid  = ($urandom_range(0, 1) == 0);
      rx_data   = 8'($urandom);
      rx_pe     = 1'($urandom);
      rx_fe     = 1'($urandom);
      char_tick = ($urandom_range(0, 2) == 0);
      rd_en     = (i % 300 < 150) ? ($urandom_range(0, 5) == 0)
                                  : ($urandom_range(0, 1) == 0);
      lsr_rd    = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_ctrl.md
# uart_rx_fifo_ctrl

Receive-side FIFO controller for the 16550-style UART. It buffers characters from the receiver shift logic in a 16-entry FIFO, or in a 1-entry holding register when FIFOs are disabled. It applies the FIFO control register settings (FIFOEN, RXCLR, RXFIFTL) and raises data-ready, overrun, trigger-level and character-timeout indications toward the line status and interrupt logic. It sits between the UART receiver and the CPU/ESP8266-facing register read path.

## Interface
- DEPTH, 16, FIFO entries when FIFOEN=1 (power of two)
- TO_CHARS, 4, character times of inactivity before timeout
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- FIFOEN  in  1  FIFO enable from FCR; 0 selects 1-entry holding mode
- RXCLR  in  1  one-cycle RX FIFO clear pulse from FCR
- RXFIFTL  in  2  trigger level select: 00=1, 01=4, 10=8, 11=14
- rx_valid  in  1  one-cycle pulse, new character from receiver
- rx_data  in  8  received character
- rx_pe, rx_fe  in  1 each  parity/framing error of that character
- char_tick  in  1  one-cycle pulse per character time from baud generator
- rd_en  in  1  RBR read pulse (pop)
- lsr_rd  in  1  LSR read pulse (clears OE)
- rd_data  out  8  head character (show-ahead), 0 when empty
- rd_pe, rd_fe  out  1 each  error flags of head entry, 0 when empty
- DR  out  1  data ready: level != 0
- OE  out  1  sticky overrun flag
- rx_level  out  5  current occupancy 0..DEPTH
- rda  out  1  trigger reached: FIFOEN and level >= trigger, or !FIFOEN and DR
- cti  out  1  character timeout indication

## Operation
- Entries are 10 bits, {fe, pe, data}; stored in circular memory with 4-bit rd/wr pointers that wrap modulo DEPTH, plus a 5-bit count.
- Capacity: DEPTH when FIFOEN=1, 1 when FIFOEN=0.
- Push on rx_valid when count < capacity. Push when full: character discarded, FIFO unchanged, OE<=1.
- Pop on rd_en when count > 0; rd_en when empty is ignored.
- Simultaneous push and pop while full: both are accepted, count is unchanged, and OE is not set.
- Flush (pointers and count to 0, timeout counter to 0) on RXCLR, or when FIFOEN differs from its registered previous value. OE is not affected by a flush.
- OE clears on lsr_rd. If lsr_rd and a new overrun occur in the same cycle, OE stays 1.
- Timeout counter (3 bits) resets to 0 on any push, pop, flush, or while count=0. Otherwise it increments on char_tick, saturating at TO_CHARS.
- cti = FIFOEN & (count != 0) & (counter == TO_CHARS). It stays asserted until the next push, pop or flush.
- In holding mode (FIFOEN=0), cti=0 permanently.

## Timing
- Reset: pointers, count, rx_level, DR, OE, rda, cti, timeout counter all 0. Previous-FIFOEN register loads the current FIFOEN so that reset itself is not followed by a flush.
- rd_data, rd_pe and rd_fe are combinational from the head entry. A pop is visible in the cycle after the rd_en edge.
- DR, rx_level and rda are derived from the registered count, so they update one cycle after a push or pop.
- OE is registered and is set in the cycle after an overrun.
- A flush takes effect in the cycle after RXCLR or a FIFOEN change. A push arriving in the same cycle as the flush is discarded.
- Reset has priority over flush, flush over push/pop.
- Trigger compare is unsigned 5-bit: level >= {1,4,8,14}[RXFIFTL]. RXFIFTL is sampled live, with no latching.

## Structure
- Shared package uart_pkg:
  - trigger-level constants TRIG_1/4/8/14
  - RXFIFTL encoding localparams
  - RX entry width (10)
  - DEPTH default
- Sub-module uart_fifo_mem: DEPTHx10 register-file memory with synchronous write and asynchronous read. It is reused later for the TX side.
- The controller holds pointers, count, OE, the timeout counter and flag logic.

## Test plan
- Reset, FIFOEN=1, RXFIFTL=01: push 0x41, 0x42, 0x43 -> DR=1, rx_level=3, rda=0. Push 0x44 -> rda=1. Pop four -> reads 41,42,43,44 in order, DR=0.
- Fill 16 entries, push 0x99 -> OE=1, entry 0x99 absent, level=16. Assert lsr_rd -> OE=0. Push with a pop in the same cycle when full -> level stays 16, OE stays 0.
- FIFOEN=0: push 0x10 then 0x11 without a read -> rd_data=0x10, OE=1, rda=1, cti never asserts.
- FIFOEN=1, push 1 char, then 4 char_tick pulses with no activity -> cti=1 after the 4th. Pop -> cti=0, DR=0.
- Load 5 entries, pulse RXCLR with rx_valid in the same cycle -> level=0, DR=0, OE unchanged. Toggling FIFOEN with data present -> flush.
- Push an entry with rx_fe=1, rx_pe=0 -> rd_fe=1, rd_pe=0 at head. Wrap pointers through 40 push/pop cycles -> data order preserved.
